// File: rtl/legv8_pkg.sv
// legv8_pkg: op codes, encoding constants, immediate limits and loader FSM states for the LEGv8 encoder
package legv8_pkg;
    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_ORR  = 3'd3,
        OP_LDUR = 3'd4,
        OP_STUR = 3'd5,
        OP_CBZ  = 3'd6
    } op_e;
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_e;
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam int D_IMM_MIN  = -256;
    localparam int D_IMM_MAX  = 255;
    localparam int CB_IMM_MIN = -262144;
    localparam int CB_IMM_MAX = 262143;
endpackage

// File: rtl/legv8_encode.sv
// legv8_encode: combinational R/D/CB-format encoder with op and immediate-range checks
module legv8_encode
    import legv8_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rn,
    input  logic [4:0]  rm,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        err_op,
    output logic        err_range
);
    logic signed [31:0] simm;
    logic [10:0] opc;
    logic d_fmt, cb_fmt;
    assign simm = imm;
    always_comb begin
        d_fmt = op == OP_LDUR || op == OP_STUR;
        cb_fmt = op == OP_CBZ;
        opc = op == OP_ADD  ? OPC_ADD  :
              op == OP_SUB  ? OPC_SUB  :
              op == OP_AND  ? OPC_AND  :
              op == OP_ORR  ? OPC_ORR  :
              op == OP_LDUR ? OPC_LDUR : OPC_STUR;
        word = cb_fmt ? {OPC_CBZ, imm[18:0], rd} :
               d_fmt  ? {opc, imm[8:0], 2'b00, rn, rd} :
                        {opc, rm, 6'b000000, rn, rd};
        err_op = op == 3'd7;
        err_range = d_fmt  ? (simm < D_IMM_MIN || simm > D_IMM_MAX) :
                    cb_fmt ? (simm < CB_IMM_MIN || simm > CB_IMM_MAX) : 1'b0;
    end
endmodule

// File: rtl/legv8_instr_encoder.sv
// legv8_instr_encoder: accepts symbolic LEGv8 instructions and writes encoded words sequentially into imem
module legv8_instr_encoder
    import legv8_pkg::*;
#(
    parameter int IMEM_DEPTH = 64,
    parameter int ADDR_W = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rn,
    input  logic [4:0]        in_rm,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err_op,
    output logic              err_range
);
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(IMEM_DEPTH);
    state_e state, state_n;
    logic pend, ok, last, hs, restart, enc_err_op, enc_err_range;
    logic [31:0] word, enc;
    logic [ADDR_W:0] count_inc;
    legv8_encode u_enc (
        .op(in_op),
        .rd(in_rd),
        .rn(in_rn),
        .rm(in_rm),
        .imm(in_imm),
        .word(enc),
        .err_op(enc_err_op),
        .err_range(enc_err_range)
    );
    assign restart = start && state != S_LOAD;
    assign in_ready = state == S_LOAD && !pend && count < FULL;
    assign hs = in_valid && in_ready;
    assign count_inc = count + (ADDR_W+1)'(ok);
    assign imem_we = pend && ok && !reset;
    assign imem_addr = count[ADDR_W-1:0];
    assign imem_wdata = word;
    assign busy = state == S_LOAD;
    assign done = state == S_DONE;
    always_comb begin
        state_n = state;
        state_n = restart ? S_LOAD :
                  (state == S_LOAD && pend && (last || count_inc == FULL)) ? S_DONE : state;
    end
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= 1'b0;
            ok <= 1'b0;
            last <= 1'b0;
            word <= '0;
            count <= '0;
            err_op <= 1'b0;
            err_range <= 1'b0;
        end else if (restart) begin
            pend <= 1'b0;
            count <= '0;
            err_op <= 1'b0;
            err_range <= 1'b0;
        end else if (hs) begin
            pend <= 1'b1;
            ok <= !(enc_err_op || enc_err_range);
            last <= in_last;
            word <= enc;
            err_op <= err_op | enc_err_op;
            err_range <= err_range | enc_err_range;
        end else if (pend) begin
            pend <= 1'b0;
            count <= count_inc;
        end
    end
endmodule

// File: tb/tb_legv8_instr_encoder.sv
// tb_legv8_instr_encoder: table-driven directed checks of the LEGv8 loader encoder plus session corner cases
module tb_legv8_instr_encoder;
    localparam int DEPTH = 4;
    localparam int AW = 2;
    logic clk = 1'b0;
    logic reset, start, in_valid, in_ready, in_last, imem_we, busy, done, err_op, err_range;
    logic [2:0] in_op;
    logic [4:0] in_rd, in_rn, in_rm;
    logic [31:0] in_imm, imem_wdata;
    logic [AW-1:0] imem_addr;
    logic [AW:0] count;
    int total = 0;
    int bad = 0;
    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [31:0] imm;
        logic [31:0] word;
        logic        ok;
        logic        eo;
        logic        er;
    } vec_t;
    vec_t vecs[14];
    always #5 clk = ~clk;
    legv8_instr_encoder #(.IMEM_DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_op(in_op),
        .in_rd(in_rd),
        .in_rn(in_rn),
        .in_rm(in_rm),
        .in_imm(in_imm),
        .in_last(in_last),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .busy(busy),
        .done(done),
        .count(count),
        .err_op(err_op),
        .err_range(err_range)
    );
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic drive(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rn,
                         input logic [4:0] rm, input logic [31:0] imm, input logic last);
        in_valid = 1'b1;
        in_op = op;
        in_rd = rd;
        in_rn = rn;
        in_rm = rm;
        in_imm = imm;
        in_last = last;
    endtask
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask
    initial begin
        vecs[0]  = '{3'd0, 5'd1,  5'd2,  5'd3,  32'h00000000, 32'h8B030041, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{3'd1, 5'd31, 5'd0,  5'd31, 32'h00000000, 32'hCB1F001F, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{3'd2, 5'd4,  5'd5,  5'd6,  32'h00000000, 32'h8A0600A4, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{3'd3, 5'd10, 5'd11, 5'd12, 32'h00000000, 32'hAA0C016A, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{3'd4, 5'd0,  5'd1,  5'd0,  32'h000000FF, 32'hF84FF020, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{3'd5, 5'd3,  5'd2,  5'd0,  32'hFFFFFF00, 32'hF8100043, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{3'd4, 5'd1,  5'd1,  5'd0,  32'h00000100, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{3'd5, 5'd1,  5'd1,  5'd0,  32'hFFFFFEFF, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{3'd6, 5'd9,  5'd0,  5'd0,  32'hFFFFFFFF, 32'hB4FFFFE9, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{3'd6, 5'd0,  5'd0,  5'd0,  32'h0003FFFF, 32'hB47FFFE0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{3'd6, 5'd1,  5'd0,  5'd0,  32'hFFFC0000, 32'hB4800001, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{3'd6, 5'd9,  5'd0,  5'd0,  32'h00040000, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{3'd6, 5'd9,  5'd0,  5'd0,  32'hFFFBFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{3'd7, 5'd1,  5'd2,  5'd3,  32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0};
        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_op = 3'd0;
        in_rd = 5'd0;
        in_rn = 5'd0;
        in_rm = 5'd0;
        in_imm = 32'd0;
        in_last = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_errs", {err_op, err_range}, 0);
        for (int i = 0; i < 14; i++) begin
            pulse_start();
            chk($sformatf("v%0d_busy", i), busy, 1);
            chk($sformatf("v%0d_ready", i), in_ready, 1);
            drive(vecs[i].op, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].imm, 1'b1);
            tick();
            in_valid = 1'b0;
            in_last = 1'b0;
            chk($sformatf("v%0d_we", i), imem_we, vecs[i].ok);
            if (vecs[i].ok) begin
                chk($sformatf("v%0d_wdata", i), imem_wdata, vecs[i].word);
                chk($sformatf("v%0d_addr", i), imem_addr, 0);
            end
            tick();
            chk($sformatf("v%0d_done", i), done, 1);
            chk($sformatf("v%0d_count", i), count, vecs[i].ok);
            chk($sformatf("v%0d_err_op", i), err_op, vecs[i].eo);
            chk($sformatf("v%0d_err_range", i), err_range, vecs[i].er);
            chk($sformatf("v%0d_ready_done", i), in_ready, 0);
        end
        pulse_start();
        chk("restart_err_op", err_op, 0);
        chk("restart_count", count, 0);
        drive(3'd4, 5'd5, 5'd6, 5'd0, 32'hFFFFFFF8, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("seq_we0", imem_we, 1);
        chk("seq_addr0", imem_addr, 0);
        chk("seq_wdata0", imem_wdata, 32'hF85F80C5);
        chk("seq_ready_pend", in_ready, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("seq_start_ignored", count, 1);
        chk("seq_busy", busy, 1);
        drive(3'd5, 5'd7, 5'd6, 5'd0, 32'h00000010, 1'b1);
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
        chk("seq_we1", imem_we, 1);
        chk("seq_addr1", imem_addr, 1);
        chk("seq_wdata1", imem_wdata, 32'hF80100C7);
        tick();
        chk("seq_done", done, 1);
        chk("seq_count", count, 2);
        pulse_start();
        drive(3'd6, 5'd9, 5'd0, 5'd0, 32'h00040000, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("rej_we", imem_we, 0);
        tick();
        chk("rej_count", count, 0);
        chk("rej_busy", busy, 1);
        chk("rej_err_range", err_range, 1);
        drive(3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1);
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
        chk("rej_next_addr", imem_addr, 0);
        chk("rej_next_wdata", {imem_we, imem_wdata}, {1'b1, 32'h8B030041});
        tick();
        chk("rej_sticky", {done, err_range, count}, {1'b1, 1'b1, 3'd1});
        begin
            int writes, hss;
            writes = 0;
            hss = 0;
            pulse_start();
            drive(3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
            for (int c = 0; c < 14; c++) begin
                if (in_valid && in_ready) hss++;
                tick();
                if (imem_we) begin
                    chk($sformatf("full_addr%0d", writes), imem_addr, writes);
                    chk($sformatf("full_wdata%0d", writes), imem_wdata, 32'h8B030041);
                    writes++;
                end
            end
            in_valid = 1'b0;
            chk("full_writes", writes, 4);
            chk("full_handshakes", hss, 4);
            chk("full_done", done, 1);
            chk("full_count", count, 4);
            chk("full_errs", {err_op, err_range}, 0);
        end
        pulse_start();
        drive(3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
        tick();
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_reset_we", imem_we, 0);
        tick();
        reset = 1'b0;
        chk("post_reset_outs", {imem_we, imem_addr, busy, done, count, err_op, err_range, in_ready}, 0);
        chk("post_reset_wdata", imem_wdata, 0);
        tick();
        chk("post_reset_idle", {busy, done, imem_we}, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
